// File: rtl/operand_fetch_bypass_stage_pkg.sv
// Shared types and default sizes for the operand fetch / bypass stage.
package operand_fetch_bypass_stage_pkg;
    localparam int DEF_NUM_THREADS = 4;
    localparam int DEF_NUM_LANES   = 16;
    localparam int DEF_NUM_REGS    = 32;
    localparam int DEF_DATA_WIDTH  = 32;

    typedef logic [$clog2(DEF_NUM_THREADS)-1:0] thread_idx_t;
    typedef logic [$clog2(DEF_NUM_REGS)-1:0]    reg_idx_t;
    typedef logic [DEF_DATA_WIDTH-1:0]          lane_data_t;

    // Where the lane mask comes from.
    typedef enum logic [1:0] {
        MASK_ALL  = 2'd0,
        MASK_SRC1 = 2'd1,
        MASK_SRC2 = 2'd2
    } mask_src_t;
endpackage

// File: rtl/operand_bypass_lane.sv
// One operand lane: shows fresh memory read data in the cycle after an
// accept unless that lane was forwarded, then keeps the value in a hold
// register that also absorbs writes to the held source.
module operand_bypass_lane #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         accept,
    input  logic         acc_load,
    input  logic [W-1:0] acc_data,
    input  logic         upd,
    input  logic [W-1:0] upd_data,
    input  logic [W-1:0] rdata,
    output logic [W-1:0] value
);
    logic         use_rdata_reg;
    logic [W-1:0] held_reg;

    assign value = use_rdata_reg ? rdata : held_reg;

    // Capture forwarded/immediate data on accept, otherwise track the lane.
    always_ff @(posedge clk) begin
        if (!reset) begin
            use_rdata_reg <= 1'b0;
            held_reg      <= '0;
        end else if (accept) begin
            use_rdata_reg <= !acc_load;
            held_reg      <= acc_data;
        end else begin
            use_rdata_reg <= 1'b0;
            held_reg      <= upd ? upd_data : value;
        end
    end
endmodule

// File: rtl/sram_2r1w.sv
// Two-read / one-write memory with registered read ports; reads see the
// contents from before a same-cycle write. Contents are never reset.
module sram_2r1w #(
    parameter int DEPTH      = 128,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [WIDTH-1:0]      rdata1,
    output logic [WIDTH-1:0]      rdata2,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port plus both registered read ports.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata1 <= mem[raddr1];
            rdata2 <= mem[raddr2];
        end
    end
endmodule

// File: rtl/operand_fetch_bypass_stage.sv
// Operand fetch stage: reads scalar/vector register files, forwards
// same-cycle writebacks, holds under backpressure and honours rollback.
module operand_fetch_bypass_stage
    import operand_fetch_bypass_stage_pkg::*;
#(
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                ts_valid,
    output logic                                ts_ready,
    input  logic [$clog2(NUM_THREADS)-1:0]      ts_thread_idx,
    input  logic [$clog2(NUM_REGS)-1:0]         ts_src1_sel,
    input  logic [$clog2(NUM_REGS)-1:0]         ts_src2_sel,
    input  logic                                ts_src1_vector,
    input  logic                                ts_src2_vector,
    input  logic                                ts_op2_imm_en,
    input  logic [DATA_WIDTH-1:0]               ts_immediate,
    input  logic [1:0]                          ts_mask_src,
    output logic                                of_valid,
    input  logic                                of_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0]     of_operand1,
    output logic [NUM_LANES*DATA_WIDTH-1:0]     of_operand2,
    output logic [NUM_LANES-1:0]                of_mask,
    output logic [$clog2(NUM_THREADS)-1:0]      of_thread_idx,
    input  logic                                wb_en,
    input  logic [$clog2(NUM_THREADS)-1:0]      wb_thread_idx,
    input  logic [$clog2(NUM_REGS)-1:0]         wb_reg,
    input  logic                                wb_vector,
    input  logic [NUM_LANES-1:0]                wb_mask,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]     wb_value,
    input  logic                                rollback_en,
    input  logic [$clog2(NUM_THREADS)-1:0]      rollback_thread_idx
);
    localparam int TW = $clog2(NUM_THREADS);
    localparam int RW = $clog2(NUM_REGS);
    localparam int AW = TW + RW;
    localparam int DW = DATA_WIDTH;

    logic          accept, wr_ok;
    logic          valid_reg, vec1_reg, vec2_reg, imm_reg, msel2_reg, mask_all_reg;
    logic [TW-1:0] thread_reg;
    logic [RW-1:0] sel1_reg, sel2_reg, msel_reg;
    logic          m_src2, m_all;
    logic [RW-1:0] m_sel;
    logic          acc_hit1, acc_hit2, acc_hitm, upd_hit1, upd_hit2, upd_hitm;
    logic [DW-1:0] sq1, sq2;
    logic [DW-1:0] vq1 [NUM_LANES];
    logic [DW-1:0] vq2 [NUM_LANES];
    logic [NUM_LANES-1:0] mask_value;

    assign ts_ready      = !of_valid || of_ready;
    assign accept        = ts_valid && ts_ready;
    assign wr_ok         = wb_en && reset;
    assign of_valid      = valid_reg;
    assign of_thread_idx = thread_reg;
    assign of_mask       = mask_all_reg ? '1 : mask_value;

    assign m_src2 = (ts_mask_src == MASK_SRC2);
    assign m_all  = (ts_mask_src != MASK_SRC1) && !m_src2;
    assign m_sel  = m_src2 ? ts_src2_sel : ts_src1_sel;

    // Writes hitting the request being accepted (forward) or the one held.
    assign acc_hit1 = wr_ok && wb_thread_idx == ts_thread_idx && wb_reg == ts_src1_sel
                      && wb_vector == ts_src1_vector;
    assign acc_hit2 = wr_ok && wb_thread_idx == ts_thread_idx && wb_reg == ts_src2_sel
                      && wb_vector == ts_src2_vector && !ts_op2_imm_en;
    assign acc_hitm = wr_ok && wb_thread_idx == ts_thread_idx && wb_reg == m_sel && !wb_vector;
    assign upd_hit1 = wr_ok && wb_thread_idx == thread_reg && wb_reg == sel1_reg
                      && wb_vector == vec1_reg;
    assign upd_hit2 = wr_ok && wb_thread_idx == thread_reg && wb_reg == sel2_reg
                      && wb_vector == vec2_reg && !imm_reg;
    assign upd_hitm = wr_ok && wb_thread_idx == thread_reg && wb_reg == msel_reg && !wb_vector;

    // Request bookkeeping: valid flag, rollback squash and source descriptors.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_reg    <= 1'b0;
            thread_reg   <= '0;
            sel1_reg     <= '0;
            sel2_reg     <= '0;
            msel_reg     <= '0;
            vec1_reg     <= 1'b0;
            vec2_reg     <= 1'b0;
            imm_reg      <= 1'b0;
            msel2_reg    <= 1'b0;
            mask_all_reg <= 1'b0;
        end else if (accept) begin
            valid_reg    <= !(rollback_en && rollback_thread_idx == ts_thread_idx);
            thread_reg   <= ts_thread_idx;
            sel1_reg     <= ts_src1_sel;
            sel2_reg     <= ts_src2_sel;
            msel_reg     <= m_sel;
            vec1_reg     <= ts_src1_vector;
            vec2_reg     <= ts_src2_vector;
            imm_reg      <= ts_op2_imm_en;
            msel2_reg    <= m_src2;
            mask_all_reg <= m_all;
        end else if (of_ready || (rollback_en && rollback_thread_idx == thread_reg)) begin
            valid_reg <= 1'b0;
        end
    end

    sram_2r1w #(.DEPTH(NUM_THREADS*NUM_REGS), .WIDTH(DW), .ADDR_WIDTH(AW)) u_scalar_rf (
        .clk(clk), .re(accept),
        .raddr1({ts_thread_idx, ts_src1_sel}), .raddr2({ts_thread_idx, ts_src2_sel}),
        .rdata1(sq1), .rdata2(sq2),
        .we(wr_ok && !wb_vector), .waddr({wb_thread_idx, wb_reg}), .wdata(wb_value[DW-1:0])
    );

    operand_bypass_lane #(.W(NUM_LANES)) u_mask_lane (
        .clk(clk), .reset(reset), .accept(accept),
        .acc_load(acc_hitm), .acc_data(wb_value[NUM_LANES-1:0]),
        .upd(upd_hitm), .upd_data(wb_value[NUM_LANES-1:0]),
        .rdata(msel2_reg ? sq2[NUM_LANES-1:0] : sq1[NUM_LANES-1:0]),
        .value(mask_value)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic          lane_en;
            logic [DW-1:0] lane_wdata;

            // Scalar writes cover every lane with the lane-0 value.
            assign lane_en    = !wb_vector || wb_mask[NUM_LANES-1-gi];
            assign lane_wdata = wb_vector ? wb_value[gi*DW +: DW] : wb_value[DW-1:0];

            sram_2r1w #(.DEPTH(NUM_THREADS*NUM_REGS), .WIDTH(DW), .ADDR_WIDTH(AW)) u_vector_rf (
                .clk(clk), .re(accept),
                .raddr1({ts_thread_idx, ts_src1_sel}), .raddr2({ts_thread_idx, ts_src2_sel}),
                .rdata1(vq1[gi]), .rdata2(vq2[gi]),
                .we(wr_ok && wb_vector && wb_mask[NUM_LANES-1-gi]),
                .waddr({wb_thread_idx, wb_reg}), .wdata(wb_value[gi*DW +: DW])
            );

            operand_bypass_lane #(.W(DW)) u_op1 (
                .clk(clk), .reset(reset), .accept(accept),
                .acc_load(acc_hit1 && lane_en), .acc_data(lane_wdata),
                .upd(upd_hit1 && lane_en), .upd_data(lane_wdata),
                .rdata(vec1_reg ? vq1[gi] : sq1),
                .value(of_operand1[gi*DW +: DW])
            );

            operand_bypass_lane #(.W(DW)) u_op2 (
                .clk(clk), .reset(reset), .accept(accept),
                .acc_load(ts_op2_imm_en || (acc_hit2 && lane_en)),
                .acc_data(ts_op2_imm_en ? ts_immediate : lane_wdata),
                .upd(upd_hit2 && lane_en), .upd_data(lane_wdata),
                .rdata(vec2_reg ? vq2[gi] : sq2),
                .value(of_operand2[gi*DW +: DW])
            );
        end
    endgenerate
endmodule

// File: tb/tb_operand_fetch_bypass_stage.sv
// Directed scoreboard bench for operand_fetch_bypass_stage.
module tb_operand_fetch_bypass_stage;
    localparam int NT = 4, NL = 16, NR = 32, DW = 32, LW = NL*DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, ts_valid, ts_ready, ts_src1_vector, ts_src2_vector, ts_op2_imm_en;
    logic [1:0] ts_thread_idx, of_thread_idx, wb_thread_idx, rollback_thread_idx, ts_mask_src;
    logic [4:0] ts_src1_sel, ts_src2_sel, wb_reg;
    logic [DW-1:0] ts_immediate;
    logic of_valid, of_ready, wb_en, wb_vector, rollback_en;
    logic [LW-1:0] of_operand1, of_operand2, wb_value;
    logic [NL-1:0] of_mask, wb_mask;

    operand_fetch_bypass_stage #(.NUM_THREADS(NT), .NUM_LANES(NL), .NUM_REGS(NR), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .ts_valid(ts_valid), .ts_ready(ts_ready),
        .ts_thread_idx(ts_thread_idx), .ts_src1_sel(ts_src1_sel), .ts_src2_sel(ts_src2_sel),
        .ts_src1_vector(ts_src1_vector), .ts_src2_vector(ts_src2_vector),
        .ts_op2_imm_en(ts_op2_imm_en), .ts_immediate(ts_immediate), .ts_mask_src(ts_mask_src),
        .of_valid(of_valid), .of_ready(of_ready), .of_operand1(of_operand1),
        .of_operand2(of_operand2), .of_mask(of_mask), .of_thread_idx(of_thread_idx),
        .wb_en(wb_en), .wb_thread_idx(wb_thread_idx), .wb_reg(wb_reg), .wb_vector(wb_vector),
        .wb_mask(wb_mask), .wb_value(wb_value),
        .rollback_en(rollback_en), .rollback_thread_idx(rollback_thread_idx)
    );

    typedef struct packed {
        logic [LW-1:0] op1;
        logic [LW-1:0] op2;
        logic [NL-1:0] mask;
        logic [1:0]    th;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [LW-1:0] rep(input logic [DW-1:0] x);
        logic [LW-1:0] r;
        for (int k = 0; k < NL; k++) r[k*DW +: DW] = x;
        return r;
    endfunction

    function automatic logic [LW-1:0] rep_l0(input logic [DW-1:0] x, input logic [DW-1:0] l0);
        logic [LW-1:0] r;
        r = rep(x);
        r[DW-1:0] = l0;
        return r;
    endfunction

    // Lanes 0..7 keep 0x22, lanes 8..15 take the 0x00FF-masked write of 0x33.
    function automatic logic [LW-1:0] mix_v4();
        logic [LW-1:0] r;
        for (int k = 0; k < NL; k++) r[k*DW +: DW] = (k < 8) ? 32'h22 : 32'h33;
        return r;
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic [1:0] th, input logic [4:0] r, input logic vec,
                          input logic [NL-1:0] m, input logic [LW-1:0] v);
        wb_en = 1'b1; wb_thread_idx = th; wb_reg = r; wb_vector = vec; wb_mask = m; wb_value = v;
    endtask

    task automatic write(input logic [1:0] th, input logic [4:0] r, input logic vec,
                         input logic [NL-1:0] m, input logic [LW-1:0] v);
        set_wb(th, r, vec, m, v);
        tick();
        wb_en = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] th, input logic [4:0] s1, input logic v1,
                           input logic [4:0] s2, input logic v2, input logic imm_en,
                           input logic [DW-1:0] imm, input logic [1:0] ms);
        ts_valid = 1'b1; ts_thread_idx = th; ts_src1_sel = s1; ts_src1_vector = v1;
        ts_src2_sel = s2; ts_src2_vector = v2; ts_op2_imm_en = imm_en;
        ts_immediate = imm; ts_mask_src = ms;
    endtask

    task automatic issue(input logic [1:0] th, input logic [4:0] s1, input logic v1,
                         input logic [4:0] s2, input logic v2, input logic imm_en,
                         input logic [DW-1:0] imm, input logic [1:0] ms);
        set_req(th, s1, v1, s2, v2, imm_en, imm, ms);
        tick();
        ts_valid = 1'b0;
    endtask

    // Monitor: every output handshake is checked against the scoreboard head.
    initial begin : monitor
        exp_t e;
        int txn;
        txn = 0;
        forever begin
            @(negedge clk);
            if (reset && of_valid && of_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL txn%0d unexpected output thread=%0d", txn, of_thread_idx);
                end else begin
                    e = sb.pop_front();
                    if (of_operand1 !== e.op1) begin
                        miscompares++;
                        $display("FAIL txn%0d op1 got %0h expected %0h", txn, of_operand1, e.op1);
                    end else if (of_operand2 !== e.op2) begin
                        miscompares++;
                        $display("FAIL txn%0d op2 got %0h expected %0h", txn, of_operand2, e.op2);
                    end else if (of_mask !== e.mask) begin
                        miscompares++;
                        $display("FAIL txn%0d mask got %h expected %h", txn, of_mask, e.mask);
                    end else if (of_thread_idx !== e.th) begin
                        miscompares++;
                        $display("FAIL txn%0d thread got %0d expected %0d", txn, of_thread_idx, e.th);
                    end else begin
                        $display("ok txn%0d thread=%0d mask=%h", txn, of_thread_idx, of_mask);
                    end
                end
                txn++;
            end
        end
    end

    initial begin
        reset = 1'b0; ts_valid = 1'b0; of_ready = 1'b1; wb_en = 1'b0; rollback_en = 1'b0;
        ts_thread_idx = '0; ts_src1_sel = '0; ts_src2_sel = '0; ts_src1_vector = 1'b0;
        ts_src2_vector = 1'b0; ts_op2_imm_en = 1'b0; ts_immediate = '0; ts_mask_src = '0;
        wb_thread_idx = '0; wb_reg = '0; wb_vector = 1'b0; wb_mask = '0; wb_value = '0;
        rollback_thread_idx = '0;
        repeat (3) tick();
        check("reset_of_valid", of_valid, 0);
        check("reset_ts_ready", ts_ready, 1);
        check("reset_op1", of_operand1, 0);
        check("reset_op2", of_operand2, 0);
        check("reset_mask", of_mask, 0);
        check("reset_thread", of_thread_idx, 0);
        reset = 1'b1;

        // Register file setup.
        write(1, 3, 1, 16'hFFFF, rep(32'h11));
        write(0, 7, 0, 16'h0000, rep(32'h77));
        write(0, 4, 0, 16'hFFFF, rep(32'h0F0F));
        write(0, 4, 1, 16'hFFFF, rep(32'h22));
        write(3, 2, 1, 16'hFFFF, rep(32'h9));
        write(0, 6, 0, 16'h0000, rep_l0(32'hFF, 32'h66));
        write(2, 1, 0, 16'hFFFF, rep(32'h21));

        // Vector read, one-cycle latency.
        sb.push_back('{rep(32'h11), rep(32'h5), 16'hFFFF, 2'd1});
        issue(1, 3, 1, 0, 0, 1, 32'h5, 2'd0);
        check("latency_vec_read", of_valid, 1);
        tick();

        // Same-cycle scalar write forwarded to operand and mask.
        set_wb(0, 5, 0, 16'h0000, rep(32'hABCD));
        sb.push_back('{rep(32'hABCD), rep(32'h0), 16'hABCD, 2'd0});
        issue(0, 5, 0, 0, 0, 1, 32'h0, 2'd1);
        wb_en = 1'b0;
        check("latency_fwd_read", of_valid, 1);
        tick();

        // Scalar write ignored wb_mask and used only lane 0.
        sb.push_back('{rep(32'h66), rep(32'h66), 16'h0066, 2'd0});
        issue(0, 6, 0, 6, 0, 0, 32'h0, 2'd1);
        tick();

        // Partial vector write forwarded on op2; mask from scalar src2.
        set_wb(0, 4, 1, 16'h00FF, rep(32'h33));
        sb.push_back('{rep(32'hABCD), mix_v4(), 16'h0F0F, 2'd0});
        issue(0, 5, 0, 4, 1, 0, 32'h0, 2'd2);
        wb_en = 1'b0;
        tick();

        // Backpressure hold with a masked write into the held vector source.
        of_ready = 1'b0;
        sb.push_back('{rep_l0(32'h9, 32'h7), rep(32'h1), 16'hFFFF, 2'd3});
        issue(3, 2, 1, 0, 0, 1, 32'h1, 2'd0);
        for (int i = 0; i < 3; i++) begin
            check("hold_ts_ready", ts_ready, 0);
            if (i == 1) set_wb(3, 2, 1, 16'h8000, rep_l0(32'hDEAD, 32'h7));
            tick();
            wb_en = 1'b0;
        end
        check("held_lane0", of_operand1[DW-1:0], 32'h7);
        check("held_lane1", of_operand1[2*DW-1:DW], 32'h9);
        check("hold_valid", of_valid, 1);
        of_ready = 1'b1;
        tick();

        // Rollback of another thread leaves the held op alone.
        of_ready = 1'b0;
        sb.push_back('{rep(32'h21), rep(32'h2), 16'hFFFF, 2'd2});
        issue(2, 1, 0, 0, 0, 1, 32'h2, 2'd0);
        rollback_en = 1'b1; rollback_thread_idx = 2'd0;
        tick();
        rollback_en = 1'b0;
        check("rb_other_thread", of_valid, 1);
        of_ready = 1'b1;
        tick();

        // Rollback of the held op's thread squashes it.
        of_ready = 1'b0;
        issue(2, 1, 0, 0, 0, 1, 32'h2, 2'd0);
        rollback_en = 1'b1; rollback_thread_idx = 2'd2;
        tick();
        rollback_en = 1'b0;
        check("rb_held", of_valid, 0);
        of_ready = 1'b1;

        // Rollback in the accept cycle squashes the new request.
        rollback_en = 1'b1; rollback_thread_idx = 2'd1;
        issue(1, 3, 1, 0, 0, 1, 32'h4, 2'd0);
        rollback_en = 1'b0;
        check("rb_accept", of_valid, 0);

        // Back-to-back accepts, one result per cycle.
        sb.push_back('{rep(32'h11), rep(32'h1), 16'hFFFF, 2'd1});
        sb.push_back('{rep(32'hABCD), rep(32'h2), 16'hABCD, 2'd0});
        sb.push_back('{rep(32'h66), mix_v4(), 16'hFFFF, 2'd0});
        sb.push_back('{rep_l0(32'h9, 32'h7), rep(32'h3), 16'hFFFF, 2'd3});
        set_req(1, 3, 1, 0, 0, 1, 32'h1, 2'd0);
        tick();
        check("b2b_valid0", of_valid, 1);
        set_req(0, 5, 0, 0, 0, 1, 32'h2, 2'd1);
        tick();
        check("b2b_valid1", of_valid, 1);
        set_req(0, 6, 0, 4, 1, 0, 32'h0, 2'd0);
        tick();
        check("b2b_valid2", of_valid, 1);
        set_req(3, 2, 1, 0, 0, 1, 32'h3, 2'd0);
        tick();
        check("b2b_valid3", of_valid, 1);
        ts_valid = 1'b0;
        tick();
        check("b2b_drained", of_valid, 0);

        // Reset mid-stream discards the held op and ignores writes.
        of_ready = 1'b0;
        issue(1, 3, 1, 0, 0, 1, 32'h8, 2'd0);
        check("pre_reset_valid", of_valid, 1);
        set_wb(0, 7, 0, 16'hFFFF, rep(32'h99));
        reset = 1'b0;
        tick();
        wb_en = 1'b0;
        check("mid_reset_valid", of_valid, 0);
        check("mid_reset_ts_ready", ts_ready, 1);
        check("mid_reset_op1", of_operand1, 0);
        check("mid_reset_op2", of_operand2, 0);
        check("mid_reset_mask", of_mask, 0);
        check("mid_reset_thread", of_thread_idx, 0);
        reset = 1'b1;
        of_ready = 1'b1;
        tick();

        // s7 still holds its pre-reset value.
        sb.push_back('{rep(32'h77), rep(32'h0), 16'h0077, 2'd0});
        issue(0, 7, 0, 0, 0, 1, 32'h0, 2'd1);
        tick();
        tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/operand_fetch_bypass_stage.md
OPERAND_FETCH_BYPASS_STAGE -- requirements
Module: operand_fetch_bypass_stage

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_THREADS, 4, hardware threads.
- NUM_LANES, 16, vector lanes.
- NUM_REGS, 32, registers per thread per file.
- DATA_WIDTH, 32, lane/scalar width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous, active-low.
- ts_valid, in, 1, request valid.
- ts_ready, out, 1, stage can accept.
- ts_thread_idx, in, clog2(NUM_THREADS), thread.
- ts_src1_sel / ts_src2_sel, in, clog2(NUM_REGS), source registers.
- ts_src1_vector / ts_src2_vector, in, 1, source is vector (else scalar).
- ts_op2_imm_en, in, 1, operand2 from immediate.
- ts_immediate, in, DATA_WIDTH, immediate.
- ts_mask_src, in, 2, 0=all ones, 1=scalar src1, 2=scalar src2.
- of_valid, out, 1, operands valid.
- of_ready, in, 1, consumer accepts.
- of_operand1 / of_operand2, out, NUM_LANES*DATA_WIDTH, operands.
- of_mask, out, NUM_LANES, lane mask.
- of_thread_idx, out, clog2(NUM_THREADS), thread of operands.
- wb_en, in, 1, register write.
- wb_thread_idx, in, clog2(NUM_THREADS), write thread.
- wb_reg, in, clog2(NUM_REGS), write register.
- wb_vector, in, 1, vector file (else scalar).
- wb_mask, in, NUM_LANES, lane write enables.
- wb_value, in, NUM_LANES*DATA_WIDTH, write data.
- rollback_en, in, 1, squash thread.
- rollback_thread_idx, in, clog2(NUM_THREADS), squashed thread.

Function
REQ-003 Lane k SHALL occupy bits [k*DATA_WIDTH +: DATA_WIDTH]; wb_mask/of_mask bit NUM_LANES-1-k SHALL correspond to lane k.
REQ-004 ts_ready SHALL equal !of_valid || of_ready; accept = ts_valid && ts_ready.
REQ-005 Accepted request SHALL present operands with of_valid=1 on the next cycle (latency 1), unless squashed per REQ-010.
REQ-006 Scalar source SHALL be replicated to all lanes; op2 with ts_op2_imm_en SHALL be ts_immediate replicated; mask from scalar SHALL be its low NUM_LANES bits.
REQ-007 Scalar write SHALL store lane 0 of wb_value and ignore wb_mask; vector write SHALL update only lanes whose mask bit is 1.
REQ-008 Write matching an accepting read (same thread, register, file) in the same cycle SHALL forward new data for written lanes, old data for others.
REQ-009 While of_valid && !of_ready, outputs SHALL hold; a write matching a held source SHALL update held operand lanes (and derived of_mask) the next cycle.
REQ-010 rollback_en with matching thread SHALL clear of_valid next cycle for both held and same-cycle-accepted requests; non-matching thread SHALL have no effect.
REQ-011 Simultaneous of_ready handshake and accept SHALL replace output with new request, no bubble.
REQ-012 Register file contents SHALL NOT be reset; reads of never-written registers return undefined data.

Reset
REQ-013 While reset=0 at clk edge: of_valid=0, ts_ready=1 next cycle, of_operand1/2=0, of_mask=0, of_thread_idx=0; in-flight request discarded; writes during reset ignored.

Structure
REQ-014 Package defines SHALL hold thread_idx_t, reg_idx_t, lane_data_t, mask_src_t enum, parameter defaults.
REQ-015 Storage SHALL use existing sram_2r1w (one scalar, NUM_LANES vector instances); per-lane forward/hold logic SHALL be sub-module operand_bypass_lane.

Verification
REQ-016 Write v3 lanes all = 0x11 thread 1, then read v3 thread 1 -> of_operand1 all lanes 0x11 after 1 cycle.
REQ-017 Read s5 while writing s5=0xABCD same cycle, ts_mask_src=1 -> of_operand1 all 0xABCD, of_mask=0xABCD (NUM_LANES=16).
REQ-018 Hold of_ready=0 3 cycles, write v2 mask 0x8000 value lane0=0x7 -> only held lane 0 becomes 0x7; ts_ready=0 throughout.
REQ-019 Rollback thread 2 with held thread-2 op -> of_valid=0 next cycle; rollback thread 0 -> unaffected.
REQ-020 reset=0 mid-stream with of_valid=1 -> of_valid=0, outputs 0; back-to-back accepts with of_ready=1 -> one result per cycle.
